// File: rtl/sysray_pkg.sv
// Shared types and constants for the sysray systolic array and its input stager.
package sysray_pkg;

    localparam int SYS_DATA_W = 16;

    typedef logic [SYS_DATA_W-1:0] sys_data_t;

    typedef enum logic [1:0] {
        SKEW_IDLE,
        SKEW_STREAM,
        SKEW_DRAIN
    } skew_state_e;

    // Width of the drain counter, which must hold N-1 and never be zero bits wide.
    function automatic int skew_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sysray_delay_line.sv
// Data+valid shift register, DEPTH stages, shifting every cycle with no enable.
module sysray_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [DEPTH-1:0][W-1:0] data_q;
    logic [DEPTH-1:0]        valid_q;

    // NOTE: the data stages are reset too, not just valid, so a discarded tile
    // cannot leak stale values onto the array after a mid-operation reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/sysray_skew.sv
// Input stager for sysray: skews lane k by k cycles and drains the wavefront after a tile's last vector.
module sysray_skew
    import sysray_pkg::*;
#(
    parameter int N = 2,
    parameter int W = SYS_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0][W-1:0] in_data_i,
    input  logic                in_valid_i,
    input  logic                in_last_i,
    output logic                in_ready_o,
    output logic [N-1:0][W-1:0] sysdata_o,
    output logic [N-1:0]        sysdata_valid_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CW = skew_cnt_width(N);

    skew_state_e   state_q, state_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic          done_q, done_d;
    logic          accept;

    assign in_ready_o = (state_q != SKEW_DRAIN);
    assign accept     = in_valid_i && in_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SKEW_IDLE;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            SKEW_IDLE, SKEW_STREAM: begin
                if (accept) begin
                    if (!in_last_i) begin
                        state_d = SKEW_STREAM;
                    end else if (N > 1) begin
                        state_d     = SKEW_DRAIN;
                        drain_cnt_d = CW'(N - 1);
                    end else begin
                        state_d = SKEW_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            SKEW_DRAIN: begin
                drain_cnt_d = drain_cnt_q - 1'b1;
                if (drain_cnt_q == CW'(1)) begin
                    state_d = SKEW_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = SKEW_IDLE;
        endcase
    end

    // Lane k is k+1 stages deep; bubbles load zero data so invalid lanes read 0.
    for (genvar k = 0; k < N; k++) begin : g_lane
        sysray_delay_line #(
            .DEPTH (k + 1),
            .W     (W)
        ) u_line (
            .clk     (clk),
            .rst     (rst),
            .data_i  (accept ? in_data_i[k] : '0),
            .valid_i (accept),
            .data_o  (sysdata_o[k]),
            .valid_o (sysdata_valid_o[k])
        );
    end

    assign busy_o = (state_q != SKEW_IDLE);
    assign done_o = done_q;

endmodule
